// File: rtl/data_memory.sv
// Byte-addressed data memory for the single-cycle CPU: W/H/B loads and stores,
// little-endian lanes, misalign/out-of-range detection, and asynchronous clear.
module data_memory #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic [2:0]  mem_op,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        out_range
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       off;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic [31:0]       word;
    logic              is_half;
    logic              is_byte;
    logic              is_signed;
    logic [15:0]       half_sel;
    logic [7:0]        byte_sel;
    logic [3:0]        be;
    logic [31:0]       wlane;
    logic              we;
    logic [31:0]       word_d;

    always_comb begin
        off       = addr - BASE_ADDR;
        idx       = off[ADDR_W+1:2];
        lane      = off[1:0];
        word      = mem_q[idx];
        is_half   = (mem_op == 3'd1) || (mem_op == 3'd2);
        is_byte   = (mem_op == 3'd3) || (mem_op == 3'd4);
        is_signed = (mem_op == 3'd1) || (mem_op == 3'd3);

        misalign = 1'b0;
        if (is_half) begin
            misalign = lane[0];
        end else if (!is_byte) begin
            misalign = (lane != 2'd0);
        end
        // Upper offset bits catch both overshoot and the wrap of addr - BASE_ADDR.
        out_range = (addr < BASE_ADDR) || (off[31:ADDR_W+2] != '0);

        half_sel = lane[1] ? word[31:16] : word[15:0];
        byte_sel = word[8*lane +: 8];

        if (misalign || out_range) begin
            rdata = '0;
        end else if (is_half) begin
            rdata = {{16{is_signed & half_sel[15]}}, half_sel};
        end else if (is_byte) begin
            rdata = {{24{is_signed & byte_sel[7]}}, byte_sel};
        end else begin
            rdata = word;
        end
    end

    always_comb begin
        be    = 4'b1111;
        wlane = wdata;
        if (is_half) begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata[15:0]}};
        end else if (is_byte) begin
            be    = 4'b0001 << lane;
            wlane = {4{wdata[7:0]}};
        end
        for (int unsigned b = 0; b < 4; b++) begin
            word_d[8*b +: 8] = be[b] ? wlane[8*b +: 8] : word[8*b +: 8];
        end
        we = mem_write && !misalign && !out_range;
    end

    // Reset branch takes priority, so stores are blocked for as long as reset is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[ADDR_W'(i)] <= '0;
            end
        end else if (we) begin
            mem_q[idx] <= word_d;
        end
    end

endmodule
